// File: rtl/decoder_seq.sv
// decoder_seq: one-hot decoder over a position register with load, manual step and timed auto advance.
module decoder_seq #(
  parameter int W     = 2,
  parameter int DWELL = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [W-1:0]       in,
  input  logic               enable,
  input  logic               load,
  input  logic               clear,
  input  logic               step,
  input  logic               auto_en,
  input  logic               dir,
  output logic [(1<<W)-1:0]  out,
  output logic [W-1:0]       pos,
  output logic               active,
  output logic               wrap
);
  localparam int N = 1 << W;
  localparam logic [N-1:0] ONE = N'(1);
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  logic [W-1:0] pos_q, pos_d;
  logic         active_q, active_d;
  logic         wrap_q, wrap_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         run, adv;
  // Manual mode keeps the dwell counter at zero, so entering auto mode always starts a fresh dwell.
  always_comb begin
    run      = active_q && !clear && !load;
    adv      = run && (auto_en ? cnt_q == DWELL_LAST : step);
    pos_d    = (load && !clear) ? in : adv ? (dir ? pos_q - 1'b1 : pos_q + 1'b1) : pos_q;
    active_d = clear ? 1'b0 : load ? 1'b1 : active_q;
    cnt_d    = (run && auto_en && !adv) ? cnt_q + 8'd1 : 8'd0;
    wrap_d   = adv && (dir ? pos_q == '0 : pos_q == '1);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pos_q    <= '0;
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      pos_q    <= pos_d;
      active_q <= active_d;
      wrap_q   <= wrap_d;
      cnt_q    <= cnt_d;
    end
  end
  assign out    = (active_q && enable) ? ONE << pos_q : '0;
  assign pos    = pos_q;
  assign active = active_q;
  assign wrap   = wrap_q;
endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: random and directed stimulus on three builds, checked against a modular-arithmetic model.
module tb_decoder_seq;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] in_v = '0;
  logic enable = 1'b0, load = 1'b0, clear = 1'b0, step = 1'b0, auto_en = 1'b0, dir = 1'b0;
  logic [3:0] out0, out1;
  logic [1:0] out2;
  logic [1:0] pos0, pos1;
  logic [0:0] pos2;
  logic a0, a1, a2, w0, w1, w2;
  int checks = 0, errors = 0;
  int mpos[3], mcnt[3];
  bit mact[3], mwr[3];
  int nn[3] = '{4, 4, 2};
  int dw[3] = '{4, 1, 3};

  always #5 clock = ~clock;

  decoder_seq #(.W(2), .DWELL(4)) u0 (.clock(clock), .reset_n(reset_n), .in(in_v), .enable(enable),
    .load(load), .clear(clear), .step(step), .auto_en(auto_en), .dir(dir),
    .out(out0), .pos(pos0), .active(a0), .wrap(w0));
  decoder_seq #(.W(2), .DWELL(1)) u1 (.clock(clock), .reset_n(reset_n), .in(in_v), .enable(enable),
    .load(load), .clear(clear), .step(step), .auto_en(auto_en), .dir(dir),
    .out(out1), .pos(pos1), .active(a1), .wrap(w1));
  decoder_seq #(.W(1), .DWELL(3)) u2 (.clock(clock), .reset_n(reset_n), .in(in_v[0:0]), .enable(enable),
    .load(load), .clear(clear), .step(step), .auto_en(auto_en), .dir(dir),
    .out(out2), .pos(pos2), .active(a2), .wrap(w2));

  // Reference: position moves by +/-1, a move that leaves [0,N) is a wrap; auto moves after dw active cycles.
  always @(posedge clock or negedge reset_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        mpos[i] = 0; mact[i] = 0; mcnt[i] = 0; mwr[i] = 0;
      end else if (clear) begin
        mact[i] = 0; mcnt[i] = 0; mwr[i] = 0;
      end else if (load) begin
        mpos[i] = int'(in_v) % nn[i]; mact[i] = 1; mcnt[i] = 0; mwr[i] = 0;
      end else if (!mact[i]) begin
        mwr[i] = 0; mcnt[i] = 0;
      end else begin
        bit go;
        int raw;
        go = auto_en ? (mcnt[i] + 1 == dw[i]) : step;
        raw = mpos[i] + (dir ? -1 : 1);
        mwr[i] = go && (raw < 0 || raw >= nn[i]);
        if (go) mpos[i] = (raw + nn[i]) % nn[i];
        mcnt[i] = (auto_en && !go) ? mcnt[i] + 1 : 0;
      end
    end
  end

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_out(int i);
    return (mact[i] && enable) ? (1 << mpos[i]) : 0;
  endfunction

  task automatic check_all();
    check("u0.out", int'(out0), exp_out(0));
    check("u0.pos", int'(pos0), mpos[0]);
    check("u0.active", int'(a0), int'(mact[0]));
    check("u0.wrap", int'(w0), int'(mwr[0]));
    check("u1.out", int'(out1), exp_out(1));
    check("u1.pos", int'(pos1), mpos[1]);
    check("u1.active", int'(a1), int'(mact[1]));
    check("u1.wrap", int'(w1), int'(mwr[1]));
    check("u2.out", int'(out2), exp_out(2));
    check("u2.pos", int'(pos2), mpos[2]);
    check("u2.active", int'(a2), int'(mact[2]));
    check("u2.wrap", int'(w2), int'(mwr[2]));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic set(bit l, bit c, bit s, bit a, bit d, bit e, int i);
    load = l; clear = c; step = s; auto_en = a; dir = d; enable = e; in_v = 2'(i);
  endtask

  initial begin
    repeat (2) tick();
    check("reset.out", int'(out0), 0);
    check("reset.active", int'(a0), 0);
    #2 reset_n = 1'b1;
    set(0, 0, 1, 0, 0, 1, 0);
    repeat (2) tick();
    check("post_reset.active", int'(a0), 0);
    for (int i = 0; i < 4; i++) begin
      set(1, 0, 0, 0, 0, 0, i);
      tick();
      set(0, 0, 0, 0, 0, 0, i);
      #1 check("sweep.off", int'(out0), 0);
      enable = 1'b1;
      #1 check("sweep.on", int'(out0), 1 << i);
    end
    set(1, 0, 0, 0, 0, 1, 3); tick();
    set(0, 0, 1, 0, 0, 1, 0); tick();
    check("mwrap.up.pos", int'(pos0), 0);
    check("mwrap.up.wrap", int'(w0), 1);
    set(0, 0, 0, 0, 0, 1, 0); tick();
    check("mwrap.up.pulse", int'(w0), 0);
    set(1, 0, 0, 0, 0, 1, 0); tick();
    set(0, 0, 1, 0, 1, 1, 0); tick();
    check("mwrap.dn.pos", int'(pos0), 3);
    check("mwrap.dn.wrap", int'(w0), 1);
    set(1, 0, 0, 1, 0, 1, 1);
    for (int k = 0; k < 17; k++) begin
      tick();
      load = 1'b0;
      check("auto.pos", int'(pos0), (1 + k / 4) % 4);
      check("auto.wrap", int'(w0), int'(k == 12));
    end
    set(1, 0, 0, 0, 0, 1, 2); tick();
    set(1, 1, 1, 0, 0, 1, 1); tick();
    check("prio.active", int'(a0), 0);
    check("prio.out", int'(out0), 0);
    check("prio.pos", int'(pos0), 2);
    set(1, 0, 1, 0, 0, 1, 3); tick();
    check("prio.load", int'(pos0), 3);
    set(0, 1, 0, 0, 0, 1, 0); tick();
    set(0, 0, 1, 1, 1, 1, 0);
    repeat (10) tick();
    check("hold.pos", int'(pos0), 3);
    check("hold.out", int'(out0), 0);
    set(1, 0, 0, 0, 0, 1, 0); tick();
    set(0, 0, 1, 0, 0, 1, 0); repeat (2) tick();
    set(0, 0, 0, 1, 0, 1, 0); repeat (2) tick();
    check("async.pre", int'(pos0), 2);
    #2 reset_n = 1'b0;
    #1 check_all();
    check("async.out", int'(out0), 0);
    check("async.pos", int'(pos0), 0);
    check("async.active", int'(a0), 0);
    #1 reset_n = 1'b1;
    set(0, 0, 1, 0, 0, 1, 0);
    repeat (3) tick();
    check("async.step", int'(pos0), 0);
    for (int k = 0; k < 400; k++) begin
      load = ($urandom_range(7) == 0);
      clear = ($urandom_range(23) == 0);
      step = $urandom_range(1) == 1;
      if ($urandom_range(15) == 0) auto_en = ~auto_en;
      dir = ($urandom_range(5) == 0) ? ~dir : dir;
      enable = ($urandom_range(7) != 0);
      in_v = 2'($urandom_range(3));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
